// File: rtl/mest_pro_issue_ctrl.sv
// MESTPro front-end sequencer: fetch, decode-register load, issue handshake,
// completion wait, PC advance/redirect, HALT detection and issue counting.
module mest_pro_issue_ctrl #(
  parameter int             INSTR_W     = 32,
  parameter int             ADDR_W      = 8,
  parameter logic [7:0]     HALT_OPCODE = 8'hFF,
  parameter int             CNT_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_start_addr,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_valid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_decode_reg,
  output logic               o_issue_valid,
  input  logic               i_exec_ready,
  input  logic               i_exec_done,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_addr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_busy,
  output logic               o_halted,
  output logic [CNT_W-1:0]   o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] dec_q, dec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      dec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each input is only looked at in the state that owns it; everything else is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          pc_d    = i_start_addr;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_imem_valid) begin
          dec_d   = i_imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_q[INSTR_W-1 -: 8] == HALT_OPCODE) state_d = S_HALT;
        else                                      state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_exec_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_exec_done) begin
          pc_d    = i_redirect_valid ? i_redirect_addr : pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs come straight from the state register, never from inputs.
  assign o_imem_req    = (state_q == S_FETCH);
  assign o_issue_valid = (state_q == S_ISSUE);
  assign o_halted      = (state_q == S_HALT);
  assign o_busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_ISSUE) || (state_q == S_EXEC);
  assign o_pc          = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_decode_reg  = dec_q;
  assign o_instr_count = cnt_q;

endmodule
